apb_master_arbiter: RTL

- Two-requester APB master that shares one APB bus between the AHB bridge write/read path (requester 0) and a second on-chip master such as a DMA or config engine (requester 1).
- Arbitrates round-robin and latches the winner's command.
- Sequences the APB SETUP/ACCESS phases with PREADY wait states, and decodes a one-hot PSEL from the address.
- Returns read data, completion and error to the winner, with a bounded-wait timeout.

---
 rtl/apb_master_arbiter_if.sv | 39 +++
 rtl/apb_master_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter_if.sv
// Requester-side handshake and APB bus signals shared by the arbiter and its environment.
interface apb_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // requester 0 / requester 1 command channels
  logic          REQ0, WRITE0;
  logic [AW-1:0] ADDR0;
  logic [DW-1:0] WDATA0;
  logic          REQ1, WRITE1;
  logic [AW-1:0] ADDR1;
  logic [DW-1:0] WDATA1;
  // completion back to the requesters
  logic          ACK0, ACK1, ERR;
  logic [DW-1:0] RDATA;
  // APB
  logic [2:0]    PSEL;
  logic          PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  // arbiter view: drives completions and the APB request side
  modport master (
    input  REQ0, WRITE0, ADDR0, WDATA0, REQ1, WRITE1, ADDR1, WDATA1,
    input  PRDATA, PREADY, PSLVERR,
    output ACK0, ACK1, ERR, RDATA,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  // environment view: requesters plus APB slaves
  modport slave (
    output REQ0, WRITE0, ADDR0, WDATA0, REQ1, WRITE1, ADDR1, WDATA1,
    output PRDATA, PREADY, PSLVERR,
    input  ACK0, ACK1, ERR, RDATA,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: grant, SETUP/ACCESS sequencing,
// one-hot slave decode, wait states and bounded-wait timeout.
module apb_master_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic HCLK,
  input logic HRESETn,            // active-high despite the name
  apb_master_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state_q;
  logic          last_q, owner_q;
  logic [CW-1:0] cnt_q;
  logic          ack0_q, ack1_q, err_q, penable_q, pwrite_q;
  logic [DW-1:0] rdata_q, pwdata_q;
  logic [AW-1:0] paddr_q;
  logic [2:0]    psel_q;

  logic          c0, c1, gnt_vld, gnt_id, gnt_wr;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;
  logic [2:0]    gnt_sel;

  // candidates exclude the requester being acknowledged this cycle;
  // on a tie the one that did not win last time gets the bus
  always_comb begin
    c0        = bus.REQ0 & ~ack0_q;
    c1        = bus.REQ1 & ~ack1_q;
    gnt_vld   = c0 | c1;
    gnt_id    = (c0 & c1) ? ~last_q : c1;
    gnt_wr    = gnt_id ? bus.WRITE1 : bus.WRITE0;
    gnt_addr  = gnt_id ? bus.ADDR1  : bus.ADDR0;
    gnt_wdata = gnt_id ? bus.WDATA1 : bus.WDATA0;
    gnt_sel   = 3'b000;
    case (gnt_addr[AW-1:AW-2])
      2'b00:   gnt_sel = 3'b001;
      2'b01:   gnt_sel = 3'b010;
      2'b10:   gnt_sel = 3'b100;
      default: gnt_sel = 3'b000;   // unmapped
    endcase
  end

  // FSM plus all registered outputs; ACK/ERR/RDATA default to a one-cycle pulse
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 3'b000;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: if (gnt_vld) begin
          owner_q <= gnt_id;
          last_q  <= gnt_id;
          if (gnt_sel != 3'b000) begin
            state_q   <= S_SETUP;
            psel_q    <= gnt_sel;
            penable_q <= 1'b0;
            pwrite_q  <= gnt_wr;
            paddr_q   <= gnt_addr;
            pwdata_q  <= gnt_wr ? gnt_wdata : '0;
          end else begin
            // no slave behind this address: fail straight back to the owner
            ack0_q <= ~gnt_id;
            ack1_q <= gnt_id;
            err_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        S_ACCESS: begin
          if (bus.PREADY || cnt_q == CW'(TIMEOUT-1)) begin
            state_q   <= S_IDLE;
            psel_q    <= 3'b000;
            penable_q <= 1'b0;
            ack0_q    <= ~owner_q;
            ack1_q    <= owner_q;
            err_q     <= bus.PREADY ? bus.PSLVERR : 1'b1;
            rdata_q   <= (bus.PREADY && !pwrite_q) ? bus.PRDATA : '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ACK0    = ack0_q;
  assign bus.ACK1    = ack1_q;
  assign bus.ERR     = err_q;
  assign bus.RDATA   = rdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
endmodule
